vga_tile_scanner: RTL and testbench

- Pixel-timing master for the pong display.
- Generates 640x480@60 sync from the 25 MHz pixel clock and broadcasts the current game-cell coordinates (ocolcount/orowcount) to the ball, paddle and other draw units.
- Takes back their registered draw flags and composes the final registered RGB and sync outputs, aligned to the draw flags' pipeline latency.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_tile_scanner.sv | 155 +++++++++++++++
 tb/tb_vga_tile_scanner.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing, tile geometry and RGB444 colour constants.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package vga_timing_pkg;

  // Horizontal timing in pixel clocks.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Active level of both sync pulses.
  localparam bit SYNC_POL = 1'b0;

  // Game grid: 16x16 pixel cells, 40x30 of them.
  localparam int TILE_SHIFT  = 4;
  localparam int GAME_WIDTH  = 40;
  localparam int GAME_HEIGHT = 30;

  // Counter and tile-coordinate widths.
  localparam int COUNT_W = 10;
  localparam int TILE_W  = 6;
  localparam logic [TILE_W-1:0] TILE_BLANK = 6'h3F;

  typedef logic [11:0] rgb444_t;
  localparam rgb444_t FG_COLOR = 12'hFFF;
  localparam rgb444_t BG_COLOR = 12'h000;

  // Pixel/line position to cell index.
  function automatic logic [TILE_W-1:0] tile_index(input logic [COUNT_W-1:0] count,
                                                   input int shift);
    logic [COUNT_W-1:0] shifted;
    shifted = count >> shift;
    return shifted[TILE_W-1:0];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (pixels or lines) with active window and sync pulse decode.
// Latency: count is registered; oactive/osync/owrap decode the current count combinationally.
// Backpressure: none; advances whenever iadvance is high.
// Ports: clock, ireset_n; iadvance (step enable); ocount (position), oactive (inside visible
//   region), osync (sync level, SYNC_POL while in the pulse), owrap (last position and advancing).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clock,
  input  logic               ireset_n,
  input  logic               iadvance,
  output logic [COUNT_W-1:0] ocount,
  output logic               oactive,
  output logic               osync,
  output logic               owrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACT_END    = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] SYNC_START = COUNT_W'(ACTIVE + FP);
  localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(ACTIVE + FP + SYNC);

  logic [COUNT_W-1:0] count;

  assign owrap = iadvance && (count == LAST);

  always_ff @(posedge clock or negedge ireset_n) begin
    if (!ireset_n) begin
      count <= '0;
    end else if (iadvance) begin
      count <= owrap ? '0 : count + 1'b1;
    end
  end

  assign ocount  = count;
  assign oactive = (count < ACT_END);
  assign osync   = ((count >= SYNC_START) && (count < SYNC_END)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_tile_scanner.sv
// vga_tile_scanner: 640x480@60 pixel-timing master; broadcasts game-cell coordinates, composes RGB/sync.
// Latency: cell coordinates 1 cycle after the counters; RGB and syncs 3 cycles after the counters.
// Backpressure: none; free-running at the pixel clock, idraw is sampled every cycle.
// Ports: clock, ireset_n; idraw (OR of draw units' registered flags, for coordinates one cycle old);
//   ocolcount/orowcount (cell coords, 63 outside the visible area); ohsync/ovsync, ored/ogrn/oblu
//   (aligned to each other); oframe_tick (one-cycle pulse at the start of vertical blank).
module vga_tile_scanner
  import vga_timing_pkg::*;
#(
  parameter int      H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int      H_FP       = vga_timing_pkg::H_FP,
  parameter int      H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int      H_BP       = vga_timing_pkg::H_BP,
  parameter int      V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int      V_FP       = vga_timing_pkg::V_FP,
  parameter int      V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int      V_BP       = vga_timing_pkg::V_BP,
  parameter bit      SYNC_POL   = vga_timing_pkg::SYNC_POL,
  parameter int      TILE_SHIFT = vga_timing_pkg::TILE_SHIFT,
  parameter rgb444_t FG_COLOR   = vga_timing_pkg::FG_COLOR,
  parameter rgb444_t BG_COLOR   = vga_timing_pkg::BG_COLOR
) (
  input  logic              clock,
  input  logic              ireset_n,
  input  logic              idraw,
  output logic [TILE_W-1:0] ocolcount,
  output logic [TILE_W-1:0] orowcount,
  output logic              ohsync,
  output logic              ovsync,
  output logic [3:0]        ored,
  output logic [3:0]        ogrn,
  output logic [3:0]        oblu,
  output logic              oframe_tick
);

  localparam logic [COUNT_W-1:0] BLANK_LINE = COUNT_W'(V_ACTIVE);

  // Stage 0: counters.
  logic [COUNT_W-1:0] hcount;
  logic [COUNT_W-1:0] vcount;
  logic               h_active;
  logic               v_active;
  logic               hsync_raw;
  logic               vsync_raw;
  logic               h_wrap;
  // Frame boundaries are taken from the line count directly, so the vertical wrap is not consumed.
  logic               v_wrap_unused;
  logic               active_raw;

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clock    (clock),
    .ireset_n (ireset_n),
    .iadvance (1'b1),
    .ocount   (hcount),
    .oactive  (h_active),
    .osync    (hsync_raw),
    .owrap    (h_wrap)
  );

  // Lines advance on the last pixel of each line, so both axes wrap on the same edge.
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clock    (clock),
    .ireset_n (ireset_n),
    .iadvance (h_wrap),
    .ocount   (vcount),
    .oactive  (v_active),
    .osync    (vsync_raw),
    .owrap    (v_wrap_unused)
  );

  assign active_raw = h_active && v_active;

  // Stage 1: broadcast coordinates; row and column always blank together.
  logic active_d1;
  logic hsync_d1;
  logic vsync_d1;

  always_ff @(posedge clock or negedge ireset_n) begin
    if (!ireset_n) begin
      ocolcount   <= TILE_BLANK;
      orowcount   <= TILE_BLANK;
      active_d1   <= 1'b0;
      hsync_d1    <= ~SYNC_POL;
      vsync_d1    <= ~SYNC_POL;
      oframe_tick <= 1'b0;
    end else begin
      if (active_raw) begin
        ocolcount <= tile_index(hcount, TILE_SHIFT);
        orowcount <= tile_index(vcount, TILE_SHIFT);
      end else begin
        ocolcount <= TILE_BLANK;
        orowcount <= TILE_BLANK;
      end
      active_d1   <= active_raw;
      hsync_d1    <= hsync_raw;
      vsync_d1    <= vsync_raw;
      oframe_tick <= (hcount == '0) && (vcount == BLANK_LINE);
    end
  end

  // Stage 2: the draw units register their match in this cycle; idraw lines up with active_d2.
  logic active_d2;
  logic hsync_d2;
  logic vsync_d2;

  always_ff @(posedge clock or negedge ireset_n) begin
    if (!ireset_n) begin
      active_d2 <= 1'b0;
      hsync_d2  <= ~SYNC_POL;
      vsync_d2  <= ~SYNC_POL;
    end else begin
      active_d2 <= active_d1;
      hsync_d2  <= hsync_d1;
      vsync_d2  <= vsync_d1;
    end
  end

  // Stage 3: final colour; idraw is ignored outside the visible area.
  rgb444_t rgb_q;

  always_ff @(posedge clock or negedge ireset_n) begin
    if (!ireset_n) begin
      rgb_q  <= '0;
      ohsync <= ~SYNC_POL;
      ovsync <= ~SYNC_POL;
    end else begin
      if (!active_d2) begin
        rgb_q <= '0;
      end else if (idraw) begin
        rgb_q <= FG_COLOR;
      end else begin
        rgb_q <= BG_COLOR;
      end
      ohsync <= hsync_d2;
      ovsync <= vsync_d2;
    end
  end

  assign ored = rgb_q[11:8];
  assign ogrn = rgb_q[7:4];
  assign oblu = rgb_q[3:0];

endmodule

// File: tb/tb_vga_tile_scanner.sv
// tb_vga_tile_scanner: directed bench for vga_tile_scanner on a scaled-down raster.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_tile_scanner;

  // Scaled raster keeps whole frames short: 48 clocks per line, 32 lines, 8x8 cells.
  localparam int HA = 32, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 24, VFP = 2, VS = 3, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;  // 48
  localparam int VT = VA + VFP + VS + VBP;  // 32
  localparam int FRAME = HT * VT;           // 1536
  localparam int TS = 3;
  localparam logic [11:0] FG = 12'hFA5;
  localparam logic [11:0] BG = 12'h036;

  logic       clock = 1'b0;
  logic       ireset_n = 1'b0;
  logic       idraw;
  logic [5:0] ocolcount, orowcount;
  logic       ohsync, ovsync, oframe_tick;
  logic [3:0] ored, ogrn, oblu;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int draw_mode = 0;  // 0: idraw low, 1: model draw unit, 2: idraw tied high
  logic draw_q = 1'b0;

  int tc_cyc[11] = '{1, 8, 9, 32, 33, 48, 49, 385, 1136, 1153, 1537};
  int tc_col[11] = '{0, 0, 1, 3, 63, 63, 0, 0, 3, 63, 0};
  int tc_row[11] = '{0, 0, 0, 0, 63, 63, 0, 1, 2, 63, 0};

  vga_tile_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .TILE_SHIFT(TS), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .ireset_n(ireset_n), .idraw(idraw),
    .ocolcount(ocolcount), .orowcount(orowcount),
    .ohsync(ohsync), .ovsync(ovsync),
    .ored(ored), .ogrn(ogrn), .oblu(oblu),
    .oframe_tick(oframe_tick)
  );

  always #20 clock = ~clock;

  // Model draw unit: registered match on cell (2,1).
  always @(posedge clock) draw_q <= (ocolcount == 6'd2) && (orowcount == 6'd1);

  assign idraw = (draw_mode == 2) ? 1'b1 : (draw_mode == 1) ? draw_q : 1'b0;
  assign rgb = {ored, ogrn, oblu};

  // Raster position of the pixel shown at cycle n by a stage with the given latency.
  function automatic int hpos(input int n, input int lat);
    return (n - lat) % HT;
  endfunction
  function automatic int vpos(input int n, input int lat);
    return ((n - lat) / HT) % VT;
  endfunction

  function automatic logic exp_hs(input int n);
    int h;
    if (n < 3) return 1'b1;
    h = hpos(n, 3);
    return (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_vs(input int n);
    int v;
    if (n < 3) return 1'b1;
    v = vpos(n, 3);
    return (v >= VA + VFP && v < VA + VFP + VS) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [11:0] exp_rgb(input int n, input int mode);
    int h, v;
    if (n < 3) return 12'h000;
    h = hpos(n, 3);
    v = vpos(n, 3);
    if (!(h < HA && v < VA)) return 12'h000;
    if (mode == 2) return FG;
    if (mode == 1 && (h >> TS) == 2 && (v >> TS) == 1) return FG;
    return BG;
  endfunction

  function automatic logic [5:0] exp_col(input int n);
    int h, v;
    if (n < 1) return 6'h3F;
    h = hpos(n, 1);
    v = vpos(n, 1);
    return (h < HA && v < VA) ? 6'(h >> TS) : 6'h3F;
  endfunction

  function automatic logic [5:0] exp_row(input int n);
    int h, v;
    if (n < 1) return 6'h3F;
    h = hpos(n, 1);
    v = vpos(n, 1);
    return (h < HA && v < VA) ? 6'(v >> TS) : 6'h3F;
  endfunction

  function automatic logic exp_tick(input int n);
    if (n < 1) return 1'b0;
    return (hpos(n, 1) == 0 && vpos(n, 1) == VA) ? 1'b1 : 1'b0;
  endfunction

  // One pixel clock; outputs are then observed at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  // Reset, then release on a falling edge; the next rising edge is cycle 1.
  task automatic restart(input int mode);
    @(negedge clock);
    ireset_n = 1'b0;
    draw_mode = mode;
    repeat (3) @(negedge clock);
    ireset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    ireset_n = 1'b0;
    draw_mode = 2;
    repeat (10) @(negedge clock);
    n_checks++; if (ocolcount !== 6'h3F) $display("FAIL reset_col: got %0d want 63", ocolcount); else n_pass++;
    n_checks++; if (orowcount !== 6'h3F) $display("FAIL reset_row: got %0d want 63", orowcount); else n_pass++;
    n_checks++; if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb); else n_pass++;
    n_checks++; if (ohsync !== 1'b1) $display("FAIL reset_hsync: got %b want 1", ohsync); else n_pass++;
    n_checks++; if (ovsync !== 1'b1) $display("FAIL reset_vsync: got %b want 1", ovsync); else n_pass++;
    n_checks++; if (oframe_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", oframe_tick); else n_pass++;
  endtask

  task automatic test_async_reset();
    int bad = -1;
    logic got;
    restart(2);
    while (cyc < 60) step();
    // Cycle 60: coords of pixel (11,1) -> cell (1,0); colour of pixel (9,1) -> FG.
    n_checks++; if (ocolcount !== 6'd1) $display("FAIL midreset_pre_col: got %0d want 1", ocolcount); else n_pass++;
    n_checks++; if (rgb !== FG) $display("FAIL midreset_pre_rgb: got %h want %h", rgb, FG); else n_pass++;
    ireset_n = 1'b0;
    #1;
    n_checks++; if (ocolcount !== 6'h3F) $display("FAIL midreset_col: got %0d want 63", ocolcount); else n_pass++;
    n_checks++; if (orowcount !== 6'h3F) $display("FAIL midreset_row: got %0d want 63", orowcount); else n_pass++;
    n_checks++; if (rgb !== 12'h000) $display("FAIL midreset_rgb: got %h want 000", rgb); else n_pass++;
    @(negedge clock);
    @(negedge clock);
    ireset_n = 1'b1;
    cyc = 0;
    while (cyc < 89) step();
    // Cycle 89 shows pixel 38 of line 1, inside the hsync pulse.
    n_checks++; if (ohsync !== 1'b0) $display("FAIL midreset_pre_hsync: got %b want 0", ohsync); else n_pass++;
    ireset_n = 1'b0;
    #1;
    n_checks++; if (ohsync !== 1'b1) $display("FAIL midreset_hsync: got %b want 1", ohsync); else n_pass++;
    n_checks++; if (ovsync !== 1'b1) $display("FAIL midreset_vsync: got %b want 1", ovsync); else n_pass++;
    @(negedge clock);
    ireset_n = 1'b1;
    cyc = 0;
    repeat (200) begin
      step();
      if (bad < 0 && ohsync !== exp_hs(cyc)) begin bad = cyc; got = ohsync; end
    end
    n_checks++;
    if (bad >= 0) $display("FAIL restart_hsync_scan: cycle %0d got %b want %b", bad, got, exp_hs(bad));
    else n_pass++;
  endtask

  task automatic test_sync_timing();
    int bad_hs = -1, bad_vs = -1, bad_rgb = -1;
    logic g_hs, g_vs;
    logic [11:0] g_rgb;
    int hs_first = -1, hs_second = -1, hs_width = -1, vs_first = -1, vs_width = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    restart(0);
    while (cyc < 2 * FRAME + 10) begin
      step();
      if (bad_hs < 0 && ohsync !== exp_hs(cyc)) begin bad_hs = cyc; g_hs = ohsync; end
      if (bad_vs < 0 && ovsync !== exp_vs(cyc)) begin bad_vs = cyc; g_vs = ovsync; end
      if (bad_rgb < 0 && rgb !== exp_rgb(cyc, 0)) begin bad_rgb = cyc; g_rgb = rgb; end
      if (prev_hs === 1'b1 && ohsync === 1'b0) begin
        if (hs_first < 0) hs_first = cyc; else if (hs_second < 0) hs_second = cyc;
      end
      if (prev_hs === 1'b0 && ohsync === 1'b1 && hs_width < 0) hs_width = cyc - hs_first;
      if (prev_vs === 1'b1 && ovsync === 1'b0 && vs_first < 0) vs_first = cyc;
      if (prev_vs === 1'b0 && ovsync === 1'b1 && vs_width < 0) vs_width = cyc - vs_first;
      prev_hs = ohsync;
      prev_vs = ovsync;
    end
    n_checks++; if (bad_hs >= 0) $display("FAIL hsync_scan: cycle %0d got %b want %b", bad_hs, g_hs, exp_hs(bad_hs)); else n_pass++;
    n_checks++; if (bad_vs >= 0) $display("FAIL vsync_scan: cycle %0d got %b want %b", bad_vs, g_vs, exp_vs(bad_vs)); else n_pass++;
    n_checks++; if (bad_rgb >= 0) $display("FAIL bg_rgb_scan: cycle %0d got %h want %h", bad_rgb, g_rgb, exp_rgb(bad_rgb, 0)); else n_pass++;
    // 32+4 pixels to the pulse, plus 3 pipeline stages.
    n_checks++; if (hs_first != 39) $display("FAIL hsync_first: got %0d want 39", hs_first); else n_pass++;
    n_checks++; if (hs_width != 6) $display("FAIL hsync_width: got %0d want 6", hs_width); else n_pass++;
    n_checks++; if (hs_second - hs_first != 48) $display("FAIL hsync_period: got %0d want 48", hs_second - hs_first); else n_pass++;
    // Line 26 (24+2) starts at 26*48 = 1248, plus 3 stages; lasts 3 lines of 48.
    n_checks++; if (vs_first != 1251) $display("FAIL vsync_first: got %0d want 1251", vs_first); else n_pass++;
    n_checks++; if (vs_width != 144) $display("FAIL vsync_width: got %0d want 144", vs_width); else n_pass++;
  endtask

  task automatic test_tile_counts();
    int bad_c = -1, bad_r = -1, bad_pair = -1;
    logic [5:0] g_c, g_r;
    restart(0);
    while (cyc < FRAME + 40) begin
      step();
      if (bad_c < 0 && ocolcount !== exp_col(cyc)) begin bad_c = cyc; g_c = ocolcount; end
      if (bad_r < 0 && orowcount !== exp_row(cyc)) begin bad_r = cyc; g_r = orowcount; end
      if (bad_pair < 0 && ((ocolcount == 6'h3F) != (orowcount == 6'h3F))) bad_pair = cyc;
      for (int k = 0; k < 11; k++) begin
        if (cyc == tc_cyc[k]) begin
          n_checks++;
          if (ocolcount !== 6'(tc_col[k])) $display("FAIL tile_col@%0d: got %0d want %0d", cyc, ocolcount, tc_col[k]);
          else n_pass++;
          n_checks++;
          if (orowcount !== 6'(tc_row[k])) $display("FAIL tile_row@%0d: got %0d want %0d", cyc, orowcount, tc_row[k]);
          else n_pass++;
        end
      end
    end
    n_checks++; if (bad_c >= 0) $display("FAIL col_scan: cycle %0d got %0d want %0d", bad_c, g_c, exp_col(bad_c)); else n_pass++;
    n_checks++; if (bad_r >= 0) $display("FAIL row_scan: cycle %0d got %0d want %0d", bad_r, g_r, exp_row(bad_r)); else n_pass++;
    n_checks++; if (bad_pair >= 0) $display("FAIL blank_pair: cycle %0d got one blank want both", bad_pair); else n_pass++;
  endtask

  task automatic test_draw_alignment();
    int bad = -1, fg_cnt = 0, fg_first = -1, fg_last = -1;
    logic [11:0] g;
    restart(1);
    while (cyc < FRAME + 10) begin
      step();
      if (bad < 0 && rgb !== exp_rgb(cyc, 1)) begin bad = cyc; g = rgb; end
      if (cyc >= 3 && cyc <= FRAME + 2 && rgb === FG) begin
        fg_cnt++;
        if (fg_first < 0) fg_first = cyc;
        fg_last = cyc;
      end
    end
    n_checks++; if (bad >= 0) $display("FAIL draw_rgb_scan: cycle %0d got %h want %h", bad, g, exp_rgb(bad, 1)); else n_pass++;
    // Cell (2,1) = pixels 16..23 of lines 8..15.
    n_checks++; if (fg_cnt != 64) $display("FAIL draw_count: got %0d want 64", fg_cnt); else n_pass++;
    n_checks++; if (fg_first != 403) $display("FAIL draw_first: got %0d want 403", fg_first); else n_pass++;
    n_checks++; if (fg_last != 746) $display("FAIL draw_last: got %0d want 746", fg_last); else n_pass++;
  endtask

  task automatic test_blanking();
    int bad = -1, fg_cnt = 0, sync_lit = 0;
    logic [11:0] g;
    restart(2);
    while (cyc < FRAME + 10) begin
      step();
      if (bad < 0 && rgb !== exp_rgb(cyc, 2)) begin bad = cyc; g = rgb; end
      if (cyc >= 3 && cyc <= FRAME + 2 && rgb === FG) fg_cnt++;
      if ((ohsync === 1'b0 || ovsync === 1'b0) && rgb !== 12'h000) sync_lit++;
    end
    n_checks++; if (bad >= 0) $display("FAIL blank_rgb_scan: cycle %0d got %h want %h", bad, g, exp_rgb(bad, 2)); else n_pass++;
    n_checks++; if (fg_cnt != 768) $display("FAIL blank_fg_count: got %0d want 768", fg_cnt); else n_pass++;
    n_checks++; if (sync_lit != 0) $display("FAIL blank_in_sync: got %0d lit pixels want 0", sync_lit); else n_pass++;
  endtask

  task automatic test_frame_tick();
    int bad = -1, n_ticks = 0, t_first = -1, t_second = -1, doubles = 0;
    logic g, prev = 1'b0;
    restart(0);
    while (cyc < 3 * FRAME + 10) begin
      step();
      if (bad < 0 && oframe_tick !== exp_tick(cyc)) begin bad = cyc; g = oframe_tick; end
      if (oframe_tick === 1'b1) begin
        n_ticks++;
        if (t_first < 0) t_first = cyc; else if (t_second < 0) t_second = cyc;
        if (prev === 1'b1) doubles++;
      end
      prev = oframe_tick;
    end
    n_checks++; if (bad >= 0) $display("FAIL tick_scan: cycle %0d got %b want %b", bad, g, exp_tick(bad)); else n_pass++;
    // 48*24 + 1
    n_checks++; if (t_first != 1153) $display("FAIL tick_first: got %0d want 1153", t_first); else n_pass++;
    n_checks++; if (t_second - t_first != 1536) $display("FAIL tick_period: got %0d want 1536", t_second - t_first); else n_pass++;
    n_checks++; if (n_ticks != 3) $display("FAIL tick_count: got %0d want 3", n_ticks); else n_pass++;
    n_checks++; if (doubles != 0) $display("FAIL tick_double: got %0d want 0", doubles); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_sync_timing();
    test_tile_counts();
    test_draw_alignment();
    test_blanking();
    test_frame_tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
